// File: rtl/seg_score_pkg.sv
// Shared constants for the six-digit score display: digit geometry and
// active-low 7-segment patterns ordered {g,f,e,d,c,b,a}.
package seg_score_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned SLOT_W     = 3;

    localparam logic [SEG_W-1:0] SEG_0   = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h10;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Score held as BCD digits, index 0 is the units digit.
    typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] score_t;

endpackage

// File: rtl/seg_score_decode.sv
// Combinational BCD to active-low 7-segment decoder with blanking.
module seg_decode
    import seg_score_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    input  logic             i_blank,
    output logic [SEG_W-1:0] o_seg_c
);

    // Map one nibble to its segment pattern; blank and codes 10-15 go dark.
    always_comb begin
        o_seg_c = SEG_OFF;
        if (!i_blank) begin
            case (i_bcd)
                BCD_W'(0): o_seg_c = SEG_0;
                BCD_W'(1): o_seg_c = SEG_1;
                BCD_W'(2): o_seg_c = SEG_2;
                BCD_W'(3): o_seg_c = SEG_3;
                BCD_W'(4): o_seg_c = SEG_4;
                BCD_W'(5): o_seg_c = SEG_5;
                BCD_W'(6): o_seg_c = SEG_6;
                BCD_W'(7): o_seg_c = SEG_7;
                BCD_W'(8): o_seg_c = SEG_8;
                BCD_W'(9): o_seg_c = SEG_9;
                default:   o_seg_c = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/seg_score.sv
// Six-digit BCD score counter with multiplexed active-low 7-segment output,
// leading-zero blanking and a decimal-point flash on each score event.
module seg_score
    import seg_score_pkg::*;
#(
    parameter int unsigned SCAN_MAX = 50_000,
    parameter int unsigned DP_MAX   = 12_500_000
)(
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  flag_add,
    input  logic                  snake_en,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [7:0]            dig
);

    localparam int unsigned SCAN_W = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;
    localparam int unsigned DP_W   = $clog2(DP_MAX + 1);

    logic                  r_flag_d;
    logic                  r_en_d;
    score_t                r_score;
    logic [SCAN_W-1:0]     r_scan_cnt;
    logic [SLOT_W-1:0]     r_slot;
    logic [DP_W-1:0]       r_dp_cnt;
    logic [NUM_DIGITS-1:0] r_sel;
    logic [7:0]            r_dig;

    logic                  w_evt;
    logic                  w_new_game;
    logic                  w_sat;
    logic                  w_accept;
    logic                  w_scan_wrap;
    logic                  w_dp_on;
    score_t                w_score_inc;
    logic [NUM_DIGITS-1:0] w_blank;
    logic [BCD_W-1:0]      w_cur_bcd;
    logic                  w_cur_blank;
    logic [SEG_W-1:0]      w_seg;

    assign w_evt       = flag_add & ~r_flag_d;
    assign w_new_game  = snake_en & ~r_en_d;
    assign w_accept    = w_evt & snake_en & ~w_new_game & ~w_sat;
    assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_MAX - 1));
    assign w_dp_on     = (r_slot == '0) && (r_dp_cnt != '0);
    assign w_cur_bcd   = r_score[r_slot];
    assign w_cur_blank = w_blank[r_slot];

    // Ripple BCD increment and all-nines saturation detect.
    always_comb begin
        logic v_carry;
        w_score_inc = r_score;
        w_sat       = 1'b1;
        v_carry     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_score[i] != BCD_W'(9)) begin
                w_sat = 1'b0;
            end
            if (v_carry) begin
                if (r_score[i] == BCD_W'(9)) begin
                    w_score_inc[i] = '0;
                end else begin
                    w_score_inc[i] = r_score[i] + BCD_W'(1);
                    v_carry        = 1'b0;
                end
            end
        end
    end

    // A digit blanks when it and every more-significant digit are zero.
    always_comb begin
        logic v_zero;
        v_zero  = 1'b1;
        w_blank = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            v_zero     = v_zero & (r_score[k] == '0);
            w_blank[k] = v_zero;
        end
    end

    seg_decode u_decode (
        .i_bcd   (w_cur_bcd),
        .i_blank (w_cur_blank),
        .o_seg_c (w_seg)
    );

    // Registered copies of the inputs for rising-edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_flag_d <= 1'b0;
            r_en_d   <= 1'b0;
        end else begin
            r_flag_d <= flag_add;
            r_en_d   <= snake_en;
        end
    end

    // Score register: new game clears and wins over a same-cycle event.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_score <= '0;
        end else if (w_new_game) begin
            r_score <= '0;
        end else if (w_accept) begin
            r_score <= w_score_inc;
        end
    end

    // Decimal-point timer, reloaded by every accepted event.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dp_cnt <= '0;
        end else if (w_accept) begin
            r_dp_cnt <= DP_W'(DP_MAX);
        end else if (r_dp_cnt != '0) begin
            r_dp_cnt <= r_dp_cnt - DP_W'(1);
        end
    end

    // Free-running scan counter stepping the digit slot 0..5.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_scan_cnt <= '0;
            r_slot     <= '0;
        end else if (w_scan_wrap) begin
            r_scan_cnt <= '0;
            r_slot     <= (r_slot == SLOT_W'(NUM_DIGITS - 1)) ? '0 : r_slot + SLOT_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Output stage: select and segments registered together.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sel <= '1;
            r_dig <= '1;
        end else begin
            r_sel <= ~(NUM_DIGITS'(1) << r_slot);
            r_dig <= {~w_dp_on, w_seg};
        end
    end

    assign sel = r_sel;
    assign dig = r_dig;

endmodule

// File: tb/tb_seg_score.sv
// Directed bench for seg_score with a short scan period and DP window.
module tb_seg_score;

    localparam int unsigned SCAN_MAX = 4;
    localparam int unsigned DP_MAX   = 20;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       flag_add  = 1'b0;
    logic       snake_en  = 1'b0;
    logic [5:0] sel;
    logic [7:0] dig;

    int n_cmp = 0;
    int n_bad = 0;

    seg_score #(
        .SCAN_MAX (SCAN_MAX),
        .DP_MAX   (DP_MAX)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .flag_add  (flag_add),
        .snake_en  (snake_en),
        .sel       (sel),
        .dig       (dig)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] sel_of(input int k);
        logic [5:0] one;
        one = 6'd1;
        return ~(one << k);
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Advance to the next negedge where slot k is selected; bounded.
    task automatic show(input int k, output logic [7:0] d);
        int n;
        n = 0;
        @(negedge sys_clk);
        while (sel !== sel_of(k) && n < 60) begin
            @(negedge sys_clk);
            n++;
        end
        if (sel !== sel_of(k)) begin
            check($sformatf("slot%0d_timeout", k), 8'(sel), 8'(sel_of(k)));
        end
        d = dig;
    endtask

    task automatic expect_slot(input string tag, input int k, input logic [7:0] exp);
        logic [7:0] d;
        show(k, d);
        check(tag, d, exp);
    endtask

    // Single flag_add pulse: one high cycle, one low cycle.
    task automatic pulse;
        flag_add = 1'b1;
        @(negedge sys_clk);
        flag_add = 1'b0;
        @(negedge sys_clk);
    endtask

    // Land on the first cycle of slot 4 so slot 0 follows inside the DP window.
    task automatic sync_slot4;
        logic [7:0] d;
        show(3, d);
        show(4, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d0;
        logic       seen;

        // Reset
        wait_cycles(5);
        check("rst_sel", 8'(sel), 8'h3F);
        check("rst_dig", dig, 8'hFF);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            check($sformatf("rst_scan%0d", i), 8'(sel), 8'(sel_of(i < 4 ? 0 : 1)));
            if (i == 0) check("rst_dig0", dig, 8'hC0);
        end
        expect_slot("rst_blank1", 1, 8'hFF);

        // Held flag counts once; dp lit while the timer runs
        snake_en = 1'b1;
        wait_cycles(3);
        sync_slot4;
        flag_add = 1'b1;
        seen = 1'b0;
        d0 = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (sel == sel_of(0)) begin
                seen = 1'b1;
                d0 = dig;
            end
        end
        flag_add = 1'b0;
        check("held_seen0", 8'(seen), 8'h01);
        check("held_dp_on", d0, 8'h79);
        wait_cycles(30);
        expect_slot("held_dp_off", 0, 8'hF9);
        expect_slot("held_once", 1, 8'hFF);

        // Carry 9 -> 10
        for (int i = 0; i < 9; i++) pulse;
        wait_cycles(30);
        expect_slot("carry_d0", 0, 8'hC0);
        expect_slot("carry_d1", 1, 8'hF9);
        for (int k = 2; k < 6; k++) expect_slot($sformatf("carry_blank%0d", k), k, 8'hFF);

        // Saturation at 999999
        @(negedge sys_clk);
        force dut.r_score = 24'h999998;
        @(negedge sys_clk);
        release dut.r_score;
        wait_cycles(30);
        expect_slot("pre_sat_d0", 0, 8'h80);
        expect_slot("pre_sat_d5", 5, 8'h90);
        sync_slot4;
        pulse;
        expect_slot("sat_reach_dp", 0, 8'h10);
        wait_cycles(30);
        expect_slot("sat_dp_off", 0, 8'h90);
        sync_slot4;
        pulse;
        expect_slot("sat_no_restart", 0, 8'h90);
        expect_slot("sat_hold_d1", 1, 8'h90);
        expect_slot("sat_hold_d5", 5, 8'h90);

        // New game clears, then build 42
        snake_en = 1'b0;
        wait_cycles(2);
        snake_en = 1'b1;
        wait_cycles(2);
        expect_slot("newgame_clr", 0, 8'hC0);
        for (int i = 0; i < 42; i++) pulse;
        wait_cycles(30);
        expect_slot("s42_d0", 0, 8'hA4);
        expect_slot("s42_d1", 1, 8'h99);
        expect_slot("s42_d2", 2, 8'hFF);

        // Events ignored while snake_en is low; score frozen
        snake_en = 1'b0;
        wait_cycles(2);
        pulse;
        wait_cycles(30);
        expect_slot("frozen_d0", 0, 8'hA4);
        expect_slot("frozen_d1", 1, 8'h99);

        // snake_en rise and flag edge in the same cycle: clear wins
        snake_en = 1'b1;
        flag_add = 1'b1;
        @(negedge sys_clk);
        flag_add = 1'b0;
        wait_cycles(30);
        expect_slot("clr_wins_d0", 0, 8'hC0);
        expect_slot("clr_wins_d1", 1, 8'hFF);

        // Scan order over one full frame
        sync_slot4;
        show(5, d0);
        show(0, d0);
        for (int i = 0; i < 24; i++) begin
            check($sformatf("scan%0d", i), 8'(sel), 8'(sel_of(i / 4)));
            @(negedge sys_clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
